// File: rtl/operand_requester.sv
// Expands one operand request into per-beat VRF reads for vs1/vs2, each channel credit-limited.
// Define OPERAND_REQ_STALL_CNT_EN to build the credit-stall cycle counter on stall_cycles_o.
module operand_requester #(
  parameter int VLENB         = 32,
  parameter int VRFDataWidthB = 8,
  parameter int NrVReg        = 32,
  parameter int QueueDepth    = 4,
  parameter int VlBWidth      = $clog2(8*VLENB+1),
  parameter int AddrWidth     = $clog2(NrVReg*(VLENB/VRFDataWidthB))
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   op_req_valid_i,
  output logic                   op_req_ready_o,
  input  logic [4:0]             op_req_vs1_i,
  input  logic [4:0]             op_req_vs2_i,
  input  logic [1:0]             op_req_queue_req_i,
  input  logic [VlBWidth-1:0]    op_req_vlB_i,
  output logic [1:0]             vrf_req_valid_o,
  output logic [2*AddrWidth-1:0] vrf_req_addr_o,
  input  logic [1:0]             vrf_req_gnt_i,
  input  logic [1:0]             queue_pop_i,
  output logic                   busy_o,
  output logic [31:0]            stall_cycles_o
);

  localparam int BeatsPerVReg = VLENB / VRFDataWidthB;
  localparam int NrBeats      = NrVReg * BeatsPerVReg;
  localparam int MaxBeats     = 8 * BeatsPerVReg;
  localparam int CntW         = $clog2(MaxBeats + 1);
  localparam int CredW        = $clog2(QueueDepth + 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                     state_q, state_d;
  logic [1:0][4:0]            vs_q, vs_d;
  logic [1:0][CntW-1:0]       rem_q, rem_d;
  logic [1:0][CntW-1:0]       beat_q, beat_d;
  logic [1:0][CredW-1:0]      credit_q, credit_d;
  logic [1:0]                 fire;
  logic [1:0]                 pop_ok;
  logic                       accept;

  function automatic logic [CntW-1:0] ceil_beats(input logic [VlBWidth-1:0] vlb);
    logic [VlBWidth:0] sum;
    sum = {1'b0, vlb} + (VlBWidth+1)'(VRFDataWidthB - 1);
    return CntW'(sum / (VlBWidth+1)'(VRFDataWidthB));
  endfunction

  // Register groups running past the last register wrap back to v0.
  function automatic logic [AddrWidth-1:0] beat_addr(input logic [4:0] vs,
                                                     input logic [CntW-1:0] beat);
    logic [31:0] lin;
    lin = 32'(vs) * 32'(BeatsPerVReg) + 32'(beat);
    return AddrWidth'(lin % 32'(NrBeats));
  endfunction

  assign op_req_ready_o = (state_q == IDLE) && !rst_i;
  assign accept         = op_req_valid_i && op_req_ready_o;
  assign busy_o         = (state_q == BUSY);

  always_comb begin
    state_d         = state_q;
    vs_d            = vs_q;
    rem_d           = rem_q;
    beat_d          = beat_q;
    credit_d        = credit_q;
    fire            = '0;
    pop_ok          = '0;
    vrf_req_valid_o = '0;
    vrf_req_addr_o  = '0;

    for (int c = 0; c < 2; c++) begin
      vrf_req_valid_o[c] = (state_q == BUSY) && (rem_q[c] != '0) && (credit_q[c] != '0);
      if (state_q == BUSY)
        vrf_req_addr_o[c*AddrWidth +: AddrWidth] = beat_addr(vs_q[c], beat_q[c]);
      fire[c]     = vrf_req_valid_o[c] && vrf_req_gnt_i[c];
      pop_ok[c]   = queue_pop_i[c] && (credit_q[c] != CredW'(QueueDepth));
      credit_d[c] = credit_q[c] + CredW'(pop_ok[c]) - CredW'(fire[c]);
      if (fire[c]) begin
        rem_d[c]  = rem_q[c] - CntW'(1);
        beat_d[c] = beat_q[c] + CntW'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          vs_d[0] = op_req_vs1_i;
          vs_d[1] = op_req_vs2_i;
          for (int c = 0; c < 2; c++) begin
            rem_d[c]  = op_req_queue_req_i[c] ? ceil_beats(op_req_vlB_i) : '0;
            beat_d[c] = '0;
          end
          if (rem_d != '0) state_d = BUSY;
        end
      end
      BUSY: begin
        if (rem_d == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rem_q   <= '0;
      beat_q  <= '0;
      for (int c = 0; c < 2; c++) credit_q[c] <= CredW'(QueueDepth);
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      beat_q   <= beat_d;
      credit_q <= credit_d;
    end
  end

  // Source register numbers only matter while BUSY, so they carry no reset.
  always_ff @(posedge clk_i) begin
    vs_q <= vs_d;
  end

`ifdef OPERAND_REQ_STALL_CNT_EN
  logic [31:0] stall_q;
  logic        stall_now;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    stall_now = 1'b0;
    for (int c = 0; c < 2; c++)
      if ((rem_q[c] != '0) && (credit_q[c] == '0)) stall_now = 1'b1;
    stall_now = stall_now && (state_q == BUSY);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)          stall_q <= '0;
    else if (stall_now) stall_q <= sat_inc(stall_q);
  end

  assign stall_cycles_o = stall_q;
`else
  assign stall_cycles_o = '0;
`endif

`ifndef SYNTHESIS
  // A pop with every slot already free has no entry to release.
  always @(posedge clk_i) begin
    if (!rst_i)
      for (int c = 0; c < 2; c++)
        assert (!(queue_pop_i[c] && (credit_q[c] == CredW'(QueueDepth))))
          else $warning("operand_requester: pop on channel %0d ignored at full credit", c);
  end
`endif

endmodule

// File: tb/tb_operand_requester.sv
// Bench for operand_requester: directed table, corner sequences and random traffic vs. a queue model.
module tb_operand_requester;
  localparam int QD  = 4;
  localparam int BPV = 4;
  localparam int NB  = 128;
  localparam int DW  = 8;
  localparam int AW  = 7;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          op_req_valid_i;
  logic          op_req_ready_o;
  logic [4:0]    op_req_vs1_i, op_req_vs2_i;
  logic [1:0]    op_req_queue_req_i;
  logic [8:0]    op_req_vlB_i;
  logic [1:0]    vrf_req_valid_o;
  logic [13:0]   vrf_req_addr_o;
  logic [1:0]    vrf_req_gnt_i;
  logic [1:0]    queue_pop_i;
  logic          busy_o;
  logic [31:0]   stall_cycles_o;

  always #5 clk_i = ~clk_i;

  operand_requester dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .op_req_valid_i     (op_req_valid_i),
    .op_req_ready_o     (op_req_ready_o),
    .op_req_vs1_i       (op_req_vs1_i),
    .op_req_vs2_i       (op_req_vs2_i),
    .op_req_queue_req_i (op_req_queue_req_i),
    .op_req_vlB_i       (op_req_vlB_i),
    .vrf_req_valid_o    (vrf_req_valid_o),
    .vrf_req_addr_o     (vrf_req_addr_o),
    .vrf_req_gnt_i      (vrf_req_gnt_i),
    .queue_pop_i        (queue_pop_i),
    .busy_o             (busy_o),
    .stall_cycles_o     (stall_cycles_o)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: pending beat addresses per channel, credits, busy flag, stall count.
  int          q0[$];
  int          q1[$];
  int          m_credit[2];
  bit          m_busy;
  logic [31:0] m_stall;

  int grants[2];
  int first_addr[2];
  int last_addr[2];
  int busy_cycles;

  typedef struct {
    logic [4:0] vs1;
    logic [4:0] vs2;
    logic [1:0] qreq;
    logic [8:0] vlb;
    int n0, n1, a0f, a0l, a1f, a1l, nbusy;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int mq_size(input int c);
    return (c == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int mq_front(input int c);
    return (c == 0) ? q0[0] : q1[0];
  endfunction

  function automatic bit exp_valid(input int c);
    return m_busy && (mq_size(c) > 0) && (m_credit[c] > 0);
  endfunction

  function automatic logic [1:0] pop_safe(input logic [1:0] want);
    logic [1:0] p;
    for (int c = 0; c < 2; c++) p[c] = want[c] && (m_credit[c] < QD);
    return p;
  endfunction

  task automatic check_outputs();
    int a;
    check("ready", {31'd0, op_req_ready_o}, {31'd0, !rst_i && !m_busy});
    check("busy", {31'd0, busy_o}, {31'd0, m_busy});
`ifdef OPERAND_REQ_STALL_CNT_EN
    check("stall", stall_cycles_o, m_stall);
`else
    check("stall", stall_cycles_o, 32'd0);
`endif
    for (int c = 0; c < 2; c++) begin
      a = int'(vrf_req_addr_o[c*AW +: AW]);
      check($sformatf("valid%0d", c), {31'd0, vrf_req_valid_o[c]}, {31'd0, exp_valid(c)});
      if (exp_valid(c))  check($sformatf("addr%0d", c), a, mq_front(c));
      else if (!m_busy)  check($sformatf("idle_addr%0d", c), a, 0);
      if (vrf_req_valid_o[c] && vrf_req_gnt_i[c]) begin
        grants[c]++;
        if (first_addr[c] == -1) first_addr[c] = a;
        last_addr[c] = a;
      end
    end
    if (busy_o) busy_cycles++;
  endtask

  task automatic model_update();
    bit g[2];
    bit popk;
    bit stall_now;
    int n;
    if (rst_i) begin
      q0.delete();
      q1.delete();
      m_credit = '{QD, QD};
      m_busy   = 1'b0;
      m_stall  = '0;
      return;
    end
    if (m_busy) begin
      stall_now = 1'b0;
      for (int c = 0; c < 2; c++) if (mq_size(c) > 0 && m_credit[c] == 0) stall_now = 1'b1;
      if (stall_now && m_stall != 32'hFFFF_FFFF) m_stall++;
    end
    for (int c = 0; c < 2; c++) g[c] = exp_valid(c) && vrf_req_gnt_i[c];
    for (int c = 0; c < 2; c++) begin
      popk = queue_pop_i[c] && (m_credit[c] < QD);
      m_credit[c] = m_credit[c] + int'(popk) - int'(g[c]);
      if (g[c]) begin
        if (c == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
      end
    end
    if (m_busy) begin
      if (q0.size() == 0 && q1.size() == 0) m_busy = 1'b0;
    end else if (op_req_valid_i) begin
      n = (int'(op_req_vlB_i) + DW - 1) / DW;
      for (int i = 0; i < n; i++) begin
        if (op_req_queue_req_i[0]) q0.push_back((int'(op_req_vs1_i) * BPV + i) % NB);
        if (op_req_queue_req_i[1]) q1.push_back((int'(op_req_vs2_i) * BPV + i) % NB);
      end
      m_busy = (q0.size() > 0) || (q1.size() > 0);
    end
  endtask

  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk_i);
    model_update();
    @(negedge clk_i);
  endtask

  task automatic clear_obs();
    grants = '{0, 0};
    first_addr = '{-1, -1};
    last_addr = '{-1, -1};
    busy_cycles = 0;
  endtask

  task automatic issue(input logic [4:0] vs1, input logic [4:0] vs2,
                       input logic [1:0] qreq, input logic [8:0] vlb);
    op_req_valid_i     = 1'b1;
    op_req_vs1_i       = vs1;
    op_req_vs2_i       = vs2;
    op_req_queue_req_i = qreq;
    op_req_vlB_i       = vlb;
    queue_pop_i        = pop_safe(2'b11);
    cycle();
    op_req_valid_i = 1'b0;
  endtask

  task automatic drain(input int budget);
    vrf_req_gnt_i = 2'b11;
    for (int k = 0; k < budget && (m_busy || m_credit[0] < QD || m_credit[1] < QD); k++) begin
      queue_pop_i = pop_safe(2'b11);
      cycle();
    end
    queue_pop_i = 2'b00;
    check("drain_timeout", {31'd0, m_busy}, 32'd0);
  endtask

  initial begin
    tbl[0] = '{5'd2,  5'd5,  2'b11, 9'd32,  4,  4,  8,   11,  20,  23,  4};
    tbl[1] = '{5'd3,  5'd0,  2'b01, 9'd20,  3,  0,  12,  14,  -1,  -1,  3};
    tbl[2] = '{5'd0,  5'd31, 2'b10, 9'd64,  0,  8,  -1,  -1,  124, 3,   8};
    tbl[3] = '{5'd7,  5'd9,  2'b11, 9'd1,   1,  1,  28,  28,  36,  36,  1};
    tbl[4] = '{5'd6,  5'd6,  2'b11, 9'd0,   0,  0,  -1,  -1,  -1,  -1,  0};
    tbl[5] = '{5'd6,  5'd6,  2'b00, 9'd32,  0,  0,  -1,  -1,  -1,  -1,  0};
    tbl[6] = '{5'd31, 5'd30, 2'b11, 9'd256, 32, 32, 124, 27,  120, 23,  32};

    rst_i = 1'b1;
    op_req_valid_i = 1'b0;
    op_req_vs1_i = '0;
    op_req_vs2_i = '0;
    op_req_queue_req_i = '0;
    op_req_vlB_i = '0;
    vrf_req_gnt_i = '0;
    queue_pop_i = '0;
    q0.delete();
    q1.delete();
    m_credit = '{QD, QD};
    m_busy = 1'b0;
    m_stall = '0;
    clear_obs();
    @(posedge clk_i);
    @(negedge clk_i);
    cycle();
    rst_i = 1'b0;

    // Directed table, full grant and pop rate.
    for (int t = 0; t < 7; t++) begin
      clear_obs();
      vrf_req_gnt_i = 2'b11;
      issue(tbl[t].vs1, tbl[t].vs2, tbl[t].qreq, tbl[t].vlb);
      for (int k = 0; k < 64 && m_busy; k++) begin
        queue_pop_i = pop_safe(2'b11);
        cycle();
      end
      check($sformatf("t%0d_timeout", t), {31'd0, m_busy}, 32'd0);
      check($sformatf("t%0d_n0", t), grants[0], tbl[t].n0);
      check($sformatf("t%0d_n1", t), grants[1], tbl[t].n1);
      check($sformatf("t%0d_a0first", t), first_addr[0], tbl[t].a0f);
      check($sformatf("t%0d_a0last", t), last_addr[0], tbl[t].a0l);
      check($sformatf("t%0d_a1first", t), first_addr[1], tbl[t].a1f);
      check($sformatf("t%0d_a1last", t), last_addr[1], tbl[t].a1l);
      check($sformatf("t%0d_busycyc", t), busy_cycles, tbl[t].nbusy);
    end
    drain(16);

    // Credit exhaustion: four beats only, then one pop releases exactly one more.
    clear_obs();
    vrf_req_gnt_i = 2'b11;
    queue_pop_i = 2'b00;
    issue(5'd4, 5'd0, 2'b01, 9'd64);
    queue_pop_i = 2'b00;
    for (int k = 0; k < 12; k++) cycle();
    check("nopop_grants", grants[0], 4);
    check("nopop_busy", {31'd0, busy_o}, 32'd1);
`ifdef OPERAND_REQ_STALL_CNT_EN
    check("stall_grew", {31'd0, stall_cycles_o != 0}, 32'd1);
`else
    check("stall_off", stall_cycles_o, 32'd0);
`endif
    queue_pop_i = 2'b01;
    cycle();
    queue_pop_i = 2'b00;
    for (int k = 0; k < 5; k++) cycle();
    check("onepop_grants", grants[0], 5);
    drain(40);

    // Grant and pop together at credit 1, then reset mid-request.
    clear_obs();
    vrf_req_gnt_i = 2'b01;
    queue_pop_i = 2'b00;
    issue(5'd1, 5'd0, 2'b01, 9'd256);
    queue_pop_i = 2'b00;
    for (int k = 0; k < 3; k++) cycle();
    check("cred1_grants", grants[0], 3);
    queue_pop_i = 2'b01;
    cycle();
    queue_pop_i = 2'b00;
    vrf_req_gnt_i = 2'b00;
    #1;
    check("cred1_valid_hold", {31'd0, vrf_req_valid_o[0]}, 32'd1);
    cycle();
    check("cred1_valid_hold2", {31'd0, vrf_req_valid_o[0]}, 32'd1);
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    #1;
    check("rst_valid", {30'd0, vrf_req_valid_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_ready", {31'd0, op_req_ready_o}, 32'd1);
    clear_obs();
    vrf_req_gnt_i = 2'b01;
    issue(5'd9, 5'd0, 2'b01, 9'd64);
    queue_pop_i = 2'b00;
    for (int k = 0; k < 10; k++) cycle();
    check("rst_credit_restored", grants[0], 4);
    drain(40);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int r;
      rst_i              = ($urandom_range(0, 499) == 0);
      op_req_valid_i     = ($urandom_range(0, 2) == 0);
      op_req_vs1_i       = 5'($urandom);
      op_req_vs2_i       = 5'($urandom);
      op_req_queue_req_i = 2'($urandom);
      r = $urandom_range(0, 3);
      case (r)
        0:       op_req_vlB_i = 9'd0;
        1:       op_req_vlB_i = 9'($urandom_range(1, 32));
        2:       op_req_vlB_i = 9'($urandom_range(0, 256));
        default: op_req_vlB_i = 9'd256;
      endcase
      vrf_req_gnt_i = 2'($urandom);
      queue_pop_i   = pop_safe(2'($urandom));
      cycle();
    end
    rst_i = 1'b0;
    op_req_valid_i = 1'b0;
    drain(400);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
